// File: rtl/fa16_rev_seq_pkg.sv
// Shared definitions for the fa16_rev_seq sequencer.
// Holds the datapath and counter widths and the sequencer state encoding.
package fa16_rev_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFwd,
        StHold,
        StTurnB,
        StBwd,
        StTurnF
    } state_e;

endpackage

// File: rtl/fa16_rev_seq.sv
// Sequencer for an external reversible 16-bit adder (fa16_rev, instantiated by the parent).
// An operation runs the adder forward, offers the sum, then runs the adder backward
// ("uncompute") and checks that the original operands come back.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake; in_a, in_b, in_cin operands
//   out_valid/out_ready         result handshake; out_sum, out_cout captured result
//   busy                        high whenever the sequencer is not idle
//   err_sticky/err_clr          uncompute mismatch flag and its clear
//   dir                         adder direction, 0 forward, 1 backward
//   f_a, f_b, f_c0_f, f_z       forward drive;  f_s, f_a_b, f_c0_b, f_c15 forward results
//   r_s, r_a_b, r_c0_b, r_c15   backward drive; r_a, r_b, r_c0_f, r_z recovered inputs
module fa16_rev_seq
    import fa16_rev_seq_pkg::*;
#(
    parameter int unsigned FWD_CYC  = 2,
    parameter int unsigned BWD_CYC  = 2,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              busy,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic              dir,
    output logic [DATA_W-1:0] f_a,
    output logic [DATA_W-1:0] f_b,
    output logic              f_c0_f,
    output logic              f_z,
    input  logic [DATA_W-1:0] f_s,
    input  logic [DATA_W-1:0] f_a_b,
    input  logic              f_c0_b,
    input  logic              f_c15,
    output logic [DATA_W-1:0] r_s,
    output logic [DATA_W-1:0] r_a_b,
    output logic              r_c0_b,
    output logic              r_c15,
    input  logic [DATA_W-1:0] r_a,
    input  logic [DATA_W-1:0] r_b,
    input  logic              r_c0_f,
    input  logic              r_z
);

    // Counter reload values: a phase of N cycles loads N-1 and ends when the counter hits 0.
    localparam logic [CNT_W-1:0] FWD_LD  = CNT_W'(FWD_CYC - 1);
    localparam logic [CNT_W-1:0] BWD_LD  = CNT_W'(BWD_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              live_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              cin_q;
    logic [DATA_W-1:0] sum_q, a_b_q;
    logic              c0_b_q, cout_q;
    logic              err_q, err_d;
    logic              latch, capture, compare, mismatch;
    logic              in_fwd, in_bwd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        capture = 1'b0;
        compare = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    latch   = 1'b1;
                    state_d = StFwd;
                    cnt_d   = FWD_LD;
                end
            end
            StFwd: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (TURN_CYC == 0) begin
                        state_d = StBwd;
                        cnt_d   = BWD_LD;
                    end else begin
                        state_d = StTurnB;
                        cnt_d   = TURN_LD;
                    end
                end
            end
            StTurnB: begin
                if (cnt_q == '0) begin
                    state_d = StBwd;
                    cnt_d   = BWD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StBwd: begin
                if (cnt_q == '0) begin
                    compare = 1'b1;
                    if (TURN_CYC == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StTurnF;
                        cnt_d   = TURN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StTurnF: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A correct uncompute returns exactly the latched operands and a clean zero ancilla.
    assign mismatch = (r_a != a_q) || (r_b != b_q) || (r_c0_f != cin_q) || (r_z != 1'b0);
    // Set wins over clear so a fault coinciding with err_clr is never lost.
    assign err_d    = (err_q & ~err_clr) | (compare & mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            a_b_q   <= '0;
            c0_b_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            err_q   <= err_d;
            if (latch) begin
                a_q   <= in_a;
                b_q   <= in_b;
                cin_q <= in_cin;
            end
            if (capture) begin
                sum_q  <= f_s;
                a_b_q  <= f_a_b;
                c0_b_q <= f_c0_b;
                cout_q <= f_c15;
            end
        end
    end

    assign in_fwd = (state_q == StFwd);
    assign in_bwd = (state_q == StBwd);

    // live_q keeps in_ready low while reset is held, even though the state reads as idle.
    assign in_ready   = (state_q == StIdle) && live_q;
    assign out_valid  = (state_q == StHold);
    assign busy       = (state_q != StIdle);
    assign dir        = (state_q == StTurnB) || in_bwd;
    assign err_sticky = err_q;
    assign out_sum    = sum_q;
    assign out_cout   = cout_q;

    assign f_a    = in_fwd ? a_q : '0;
    assign f_b    = in_fwd ? b_q : '0;
    assign f_c0_f = in_fwd ? cin_q : 1'b0;
    assign f_z    = 1'b0;

    assign r_s    = in_bwd ? sum_q : '0;
    assign r_a_b  = in_bwd ? a_b_q : '0;
    assign r_c0_b = in_bwd ? c0_b_q : 1'b0;
    assign r_c15  = in_bwd ? cout_q : 1'b0;

endmodule
